display_sequencer: RTL
======================

# display_sequencer

Controller that owns the safe-lock display path: it collects keypad digits into the 16-bit entered code, selects the display mode for the downstream display multiplexer (code / "Err" / blank), times and blinks the error indication, and clears stale entries on inactivity. It sits between the keypad debouncer / lock FSM and the display mux, whose `entered_code` and `display_mode` inputs it drives directly.

## Interface
- `ERR_CYCLES`, 150_000_000, total cycles the error indication is shown (3 s at 50 MHz); minimum 2.
- `BLINK_CYCLES`, 25_000_000, half-period of the error blink in cycles; minimum 1.
- `TIMEOUT_CYCLES`, 500_000_000, entry inactivity limit in cycles; minimum 2.
- `clk` in 1: system clock; all state changes on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `digit_valid` in 1: single-cycle pulse; `digit` is valid.
- `digit` in 4: BCD keypad value. 0xA–0xF are never accepted because they are reserved for display glyphs.
- `clear_btn` in 1: single-cycle clear request.
- `verify_pass` in 1: single-cycle pulse from the lock FSM; code accepted.
- `verify_fail` in 1: single-cycle pulse from the lock FSM; code rejected.
- `display_mode` out 3: one-hot. 3'b010 = code, 3'b001 = Err, 3'b100 = blank.
- `entered_code` out 16: four nibbles, most recent digit in [3:0].
- `digit_count` out 3: digits held, 0..4.
- `code_ready` out 1: high while `digit_count` == 4 in ENTRY.
- `err_active` out 1: high throughout ERROR.

## Operation
- States:
  - IDLE: mode blank, code 0.
  - ENTRY: mode code.
  - ERROR: mode alternates Err and blank.
  - OPEN: mode code, entered code held.
- Input priority within one cycle: `verify_fail` > `verify_pass` > `clear_btn` > `digit_valid`. Only the highest-priority applicable event acts.
- Accepted digit: `digit_valid` with `digit` ≤ 9. An out-of-range digit is dropped and does not restart the timeout.
- IDLE:
  - Accepted digit: go to ENTRY, `entered_code` = {12'h000, digit}, count = 1.
  - All other inputs are ignored.
- ENTRY:
  - Accepted digit with count < 4: `entered_code` = {entered_code[11:0], digit}, count + 1, timeout restarts.
  - Digit with count == 4: ignored.
  - `clear_btn`: go to IDLE, code 0, count 0.
  - `verify_fail` / `verify_pass`: honoured only when count == 4, otherwise ignored. `verify_fail` goes to ERROR; `verify_pass` goes to OPEN.
  - Inactivity timeout: go to IDLE, code 0, count 0.
- ERROR:
  - On entry: code 0, count 0.
  - Shows Err for `BLINK_CYCLES`, then blank for `BLINK_CYCLES`, repeating.
  - After `ERR_CYCLES` cycles in ERROR: go to IDLE.
  - Digits, clear and verify pulses are all ignored.
- OPEN:
  - `entered_code` holds its value.
  - `clear_btn`: go to IDLE, code 0, count 0.
  - Everything else is ignored.

## Timing
- All outputs are registered. A response appears on the outputs at the first rising edge after the input pulse is sampled, so latency is 1 cycle.
- Reset (asynchronous, any time including mid-ERROR or mid-ENTRY):
  - State IDLE, `display_mode` 3'b100, `entered_code` 16'h0000, `digit_count` 0.
  - `code_ready` 0, `err_active` 0.
  - All timers are cleared.
- Timeout: ENTRY is left exactly `TIMEOUT_CYCLES` cycles after the ENTRY entry or the last accepted digit, whichever is later.
- ERROR duration: `err_active` is high for exactly `ERR_CYCLES` consecutive cycles.
  - The first ERROR cycle shows 3'b001; the phase toggles every `BLINK_CYCLES` cycles.
  - If `ERR_CYCLES` is not a multiple of `BLINK_CYCLES`, the last phase is truncated.
- A `verify_fail` arriving in the same cycle as the timeout expiry wins, and the state goes to ERROR.
- Timer widths are sized as $clog2 of the largest parameter. The counters saturate and never wrap.

## Structure
- Shared team parameter header holds:
  - Mode constants: MODE_ERR 3'b001, MODE_CODE 3'b010, MODE_BLANK 3'b100.
  - State encodings: IDLE, ENTRY, ERROR, OPEN.
  - Default cycle constants for 50 MHz.
- One sub-module, `seq_timer`: loadable down-counter with a `load` and an `expired` flag.
  - Instance 1: entry timeout.
  - Instance 2: error duration.
  - The blink phase uses a small local counter.

## Test plan
Benches use ERR_CYCLES=8, BLINK_CYCLES=2, TIMEOUT_CYCLES=16.

- **Entry:** reset, then digits 1,2,3,4.
  - Required: `entered_code` 16'h1234, count 4, `code_ready` 1, mode 3'b010.
  - A fifth digit 5 leaves the code at 16'h1234.
- **Fail path:** 4 digits, then `verify_fail`.
  - `display_mode` for 8 cycles: 001, 001, 100, 100, 001, 001, 100, 100, then IDLE 3'b100.
  - `entered_code` 0 throughout.
- **Pass and invalid input:** digits 9,0,0,7, then `verify_pass`.
  - Required: OPEN with 16'h9007; `clear_btn` returns to IDLE and 0.
  - Separately, `digit` 0xB in IDLE is ignored.
- **Timeout:** one digit, then idle.
  - Required: IDLE exactly 16 cycles later.
  - A second digit at cycle 10 postpones expiry to 16 cycles after that digit.
- **Simultaneous events and reset:**
  - `verify_fail` + `clear_btn` in the same cycle at count 4 goes to ERROR.
  - `verify_pass` at count 3 is ignored.
  - `rst_n` low mid-ERROR immediately gives mode 3'b100 and `err_active` 0.

Source files
------------

// File: rtl/display_sequencer_pkg.sv
// Shared constants for the safe-lock display path.
// Contents:
//   MODE_*        one-hot display mux select codes
//   state_t       sequencer state encoding
//   DEF_*         default cycle counts for a 50 MHz clock
//   max_u         helper used to size the shared timer width
package display_sequencer_pkg;

  localparam logic [2:0] MODE_ERR   = 3'b001;
  localparam logic [2:0] MODE_CODE  = 3'b010;
  localparam logic [2:0] MODE_BLANK = 3'b100;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ENTRY = 2'd1,
    ST_ERROR = 2'd2,
    ST_OPEN  = 2'd3
  } state_t;

  localparam int unsigned DEF_ERR_CYCLES     = 150_000_000;
  localparam int unsigned DEF_BLINK_CYCLES   = 25_000_000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 500_000_000;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/display_sequencer_if.sv
// Keypad / lock-FSM / display-mux signal bundle for display_sequencer.
// Signals:
//   digit_valid, digit      keypad digit pulse and BCD value
//   clear_btn               clear request pulse
//   verify_pass/fail        lock FSM verdict pulses
//   display_mode            one-hot mux select (err/code/blank)
//   entered_code            four entered nibbles, newest in [3:0]
//   digit_count             number of digits held (0..4)
//   code_ready              four digits held while entering
//   err_active              error indication in progress
// Modports: master drives the requests, slave is the sequencer.
interface display_sequencer_if;
  import display_sequencer_pkg::*;

  logic        digit_valid;
  logic [3:0]  digit;
  logic        clear_btn;
  logic        verify_pass;
  logic        verify_fail;
  logic [2:0]  display_mode;
  logic [15:0] entered_code;
  logic [2:0]  digit_count;
  logic        code_ready;
  logic        err_active;

  modport master (
    output digit_valid, digit, clear_btn, verify_pass, verify_fail,
    input  display_mode, entered_code, digit_count, code_ready, err_active
  );

  modport slave (
    input  digit_valid, digit, clear_btn, verify_pass, verify_fail,
    output display_mode, entered_code, digit_count, code_ready, err_active
  );

endinterface

// File: rtl/display_sequencer_timer.sv
// seq_timer: loadable saturating down-counter.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   load          load load_value this cycle (wins over counting)
//   load_value    start value; expired rises load_value cycles after the load
//   expired       high while the count sits at zero
module seq_timer #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_value,
  output logic             expired
);

  logic [WIDTH-1:0] count;

  // Counting stops at zero so a stale timer never wraps into a fresh interval.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (load) begin
      count <= load_value;
    end else if (count != '0) begin
      count <= count - WIDTH'(1);
    end
  end

  assign expired = (count == '0);

endmodule

// File: rtl/display_sequencer.sv
// display_sequencer: collects keypad digits, drives the display mux mode,
// blinks the error indication and clears stale entries on inactivity.
// Ports:
//   clk, rst_n    clock and asynchronous active-low reset
//   bus (slave)   keypad/lock inputs and display outputs, see the interface
// Parameters: ERR_CYCLES (error length), BLINK_CYCLES (blink half-period),
//   TIMEOUT_CYCLES (entry inactivity limit), all in clock cycles.
module display_sequencer
  import display_sequencer_pkg::*;
#(
  parameter int unsigned ERR_CYCLES     = DEF_ERR_CYCLES,
  parameter int unsigned BLINK_CYCLES   = DEF_BLINK_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input logic               clk,
  input logic               rst_n,
  display_sequencer_if.slave bus
);

  localparam int unsigned MAX_CYC = max_u(ERR_CYCLES, TIMEOUT_CYCLES);
  localparam int TW = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int BW = $clog2(BLINK_CYCLES + 1);
  localparam logic [BW-1:0] BLINK_LAST = BW'(BLINK_CYCLES - 1);

  state_t      state, state_n;
  logic [15:0] code, code_n;
  logic [2:0]  count, count_n;
  logic [BW-1:0] blink_cnt, blink_cnt_n;
  logic        blink_phase, blink_phase_n;
  logic [2:0]  mode_q, mode_n;
  logic        ready_q, err_q;
  logic        load_timeout, load_err;
  logic        timeout_expired, err_expired;
  logic        digit_ok, full;

  assign digit_ok = bus.digit_valid && (bus.digit <= 4'd9);
  assign full     = (count == 3'd4);

  // Timers are loaded with N-1 so the state changes on the Nth edge after the load.
  seq_timer #(.WIDTH(TW)) u_timeout (
    .clk(clk), .rst_n(rst_n), .load(load_timeout),
    .load_value(TW'(TIMEOUT_CYCLES - 1)), .expired(timeout_expired)
  );

  seq_timer #(.WIDTH(TW)) u_err (
    .clk(clk), .rst_n(rst_n), .load(load_err),
    .load_value(TW'(ERR_CYCLES - 1)), .expired(err_expired)
  );

  // Next-state logic; the if-chains encode fail > pass > clear > digit, with
  // the inactivity timeout only acting when nothing else did.
  always_comb begin
    state_n       = state;
    code_n        = code;
    count_n       = count;
    blink_cnt_n   = blink_cnt;
    blink_phase_n = blink_phase;
    load_timeout  = 1'b0;
    load_err      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (digit_ok) begin
          state_n      = ST_ENTRY;
          code_n       = {12'h000, bus.digit};
          count_n      = 3'd1;
          load_timeout = 1'b1;
        end
      end
      ST_ENTRY: begin
        if (bus.verify_fail && full) begin
          state_n       = ST_ERROR;
          code_n        = '0;
          count_n       = '0;
          load_err      = 1'b1;
          blink_cnt_n   = '0;
          blink_phase_n = 1'b0;
        end else if (bus.verify_pass && full) begin
          state_n = ST_OPEN;
        end else if (bus.clear_btn) begin
          state_n = ST_IDLE;
          code_n  = '0;
          count_n = '0;
        end else if (digit_ok && !full) begin
          code_n       = {code[11:0], bus.digit};
          count_n      = count + 3'd1;
          load_timeout = 1'b1;
        end else if (timeout_expired) begin
          state_n = ST_IDLE;
          code_n  = '0;
          count_n = '0;
        end
      end
      ST_ERROR: begin
        if (err_expired) begin
          state_n = ST_IDLE;
        end else if (blink_cnt == BLINK_LAST) begin
          blink_cnt_n   = '0;
          blink_phase_n = ~blink_phase;
        end else begin
          blink_cnt_n = blink_cnt + BW'(1);
        end
      end
      ST_OPEN: begin
        if (bus.clear_btn) begin
          state_n = ST_IDLE;
          code_n  = '0;
          count_n = '0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

  // Mode is decoded from the next state so the mux select comes straight off a flop.
  always_comb begin
    mode_n = MODE_BLANK;
    case (state_n)
      ST_ENTRY, ST_OPEN: mode_n = MODE_CODE;
      ST_ERROR:          mode_n = blink_phase_n ? MODE_BLANK : MODE_ERR;
      default:           mode_n = MODE_BLANK;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      code        <= '0;
      count       <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
      mode_q      <= MODE_BLANK;
      ready_q     <= 1'b0;
      err_q       <= 1'b0;
    end else begin
      state       <= state_n;
      code        <= code_n;
      count       <= count_n;
      blink_cnt   <= blink_cnt_n;
      blink_phase <= blink_phase_n;
      mode_q      <= mode_n;
      ready_q     <= (state_n == ST_ENTRY) && (count_n == 3'd4);
      err_q       <= (state_n == ST_ERROR);
    end
  end

  assign bus.display_mode = mode_q;
  assign bus.entered_code = code;
  assign bus.digit_count  = count;
  assign bus.code_ready   = ready_q;
  assign bus.err_active   = err_q;

endmodule
